// File: rtl/gpr_wb_ctrl_pkg.sv
// Shared types and constants for the GPR write-back controller.
package gpr_wb_ctrl_pkg;
   localparam int GPR_ADDR_WIDTH = 5;
   localparam int WORD_WIDTH     = 32;
   localparam int DATA_HIGH_GPR  = 32;   // number of architectural GPRs

   // GPR file write enable is active-low
   localparam logic WRITE = 1'b0;
   localparam logic READ  = 1'b1;

   typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;
   typedef logic [WORD_WIDTH-1:0]     word_t;

   typedef enum logic [1:0] {SRC_NONE, SRC_EX, SRC_BUF, SRC_MDU} wr_src_e;
endpackage

// File: rtl/gpr_wb_ctrl_if.sv
// Pipeline-side and GPR-file-side signals of the write-back controller.
interface gpr_wb_ctrl_if;
   import gpr_wb_ctrl_pkg::*;

   logic      ex_valid;
   gpr_addr_t ex_addr;
   word_t     ex_data;
   logic      mdu_valid;
   logic      mdu_ready;
   gpr_addr_t mdu_addr;
   word_t     mdu_data;
   logic      issue_valid;
   gpr_addr_t issue_addr;
   gpr_addr_t rd_addr_0;
   gpr_addr_t rd_addr_1;
   logic      hazard_0;
   logic      hazard_1;
   logic      pipe_stall;
   logic      gpr_we_;
   gpr_addr_t gpr_wr_addr;
   word_t     gpr_wr_data;
   logic      sb_err;

   // pipeline / long-latency unit / decode side
   modport master (
      output ex_valid, ex_addr, ex_data,
      output mdu_valid, mdu_addr, mdu_data,
      output issue_valid, issue_addr, rd_addr_0, rd_addr_1,
      input  mdu_ready, hazard_0, hazard_1, pipe_stall,
      input  gpr_we_, gpr_wr_addr, gpr_wr_data, sb_err
   );

   // write-back controller side
   modport slave (
      input  ex_valid, ex_addr, ex_data,
      input  mdu_valid, mdu_addr, mdu_data,
      input  issue_valid, issue_addr, rd_addr_0, rd_addr_1,
      output mdu_ready, hazard_0, hazard_1, pipe_stall,
      output gpr_we_, gpr_wr_addr, gpr_wr_data, sb_err
   );
endinterface

// File: rtl/gpr_scoreboard.sv
// Pending-destination scoreboard for long-latency results: hazard lookup
// for decode and a sticky consistency error flag.
module gpr_scoreboard
   import gpr_wb_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      issue_valid_i,
   input  gpr_addr_t issue_addr_i,
   input  logic      clr_valid_i,   // long-latency result committed to the file
   input  gpr_addr_t clr_addr_i,
   input  logic      acc_valid_i,   // long-latency result accepted by the controller
   input  gpr_addr_t acc_addr_i,
   input  logic      buf_valid_i,
   input  gpr_addr_t buf_addr_i,
   input  gpr_addr_t rd_addr_0_i,
   input  gpr_addr_t rd_addr_1_i,
   output logic      hazard_0_o,
   output logic      hazard_1_o,
   output logic      sb_err_o
);
   logic [DATA_HIGH_GPR-1:0] pending_q, pending_d;
   logic                     err_q, err_d;

   // next pending vector (set beats clear) and sticky error
   always_comb begin
      pending_d = pending_q;
      if (clr_valid_i)   pending_d[clr_addr_i]   = 1'b0;
      if (issue_valid_i) pending_d[issue_addr_i] = 1'b1;
      pending_d[0] = 1'b0;
      err_d = err_q
            | (issue_valid_i && pending_q[issue_addr_i])
            | (acc_valid_i && (acc_addr_i != '0) && !pending_q[acc_addr_i]);
   end

   // scoreboard state
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   // a result parked in the holding buffer still counts as pending for decode
   always_comb begin
      hazard_0_o = !rst && (pending_q[rd_addr_0_i] ||
                   (buf_valid_i && (buf_addr_i == rd_addr_0_i) && (rd_addr_0_i != '0)));
      hazard_1_o = !rst && (pending_q[rd_addr_1_i] ||
                   (buf_valid_i && (buf_addr_i == rd_addr_1_i) && (rd_addr_1_i != '0)));
      sb_err_o   = !rst && err_q;
   end
endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR write-back controller: shares the single file write port between the
// execute path (always wins) and the long-latency unit, with a one-entry
// holding buffer and a starvation counter that forces a pipeline stall.
module gpr_wb_ctrl
   import gpr_wb_ctrl_pkg::*;
#(
   parameter int STARVE_LIMIT = 4   // 2..15
) (
   input  logic          clk,
   input  logic          rst,
   gpr_wb_ctrl_if.slave  bus
);
   localparam int CNT_W = 4;

   logic       buf_valid_q, buf_valid_d;
   gpr_addr_t  buf_addr_q,  buf_addr_d;
   word_t      buf_data_q,  buf_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic       stall_q, stall_d;
   wr_src_e    src;
   logic       mdu_acc;
   gpr_addr_t  clr_addr;
   logic       cnt_at_limit;

   assign bus.mdu_ready = !buf_valid_q && !rst;
   assign mdu_acc       = bus.mdu_valid && bus.mdu_ready;
   assign bus.pipe_stall = stall_q && !rst;
   assign cnt_at_limit  = (cnt_q == CNT_W'(STARVE_LIMIT));

   // write-port arbitration: ex, then buffer, then mdu bypass; nothing in reset
   always_comb begin
      src = SRC_NONE;
      if (!rst) begin
         if (bus.ex_valid)       src = SRC_EX;
         else if (buf_valid_q)   src = SRC_BUF;
         else if (bus.mdu_valid) src = SRC_MDU;
      end
   end

   // GPR file write port; address 0 is consumed but never written
   always_comb begin
      bus.gpr_wr_addr = '0;
      bus.gpr_wr_data = '0;
      case (src)
         SRC_EX:  begin bus.gpr_wr_addr = bus.ex_addr;  bus.gpr_wr_data = bus.ex_data;  end
         SRC_BUF: begin bus.gpr_wr_addr = buf_addr_q;   bus.gpr_wr_data = buf_data_q;   end
         SRC_MDU: begin bus.gpr_wr_addr = bus.mdu_addr; bus.gpr_wr_data = bus.mdu_data; end
         default: ;
      endcase
      bus.gpr_we_ = ((src != SRC_NONE) && (bus.gpr_wr_addr != '0)) ? WRITE : READ;
   end

   // holding buffer, starvation counter and stall next-state
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      if (src == SRC_BUF) buf_valid_d = 1'b0;
      if (bus.ex_valid && mdu_acc) begin
         buf_valid_d = 1'b1;
         buf_addr_d  = bus.mdu_addr;
         buf_data_d  = bus.mdu_data;
      end
      cnt_d = cnt_q;
      if (!buf_valid_q)                     cnt_d = '0;
      else if (bus.ex_valid && !cnt_at_limit) cnt_d = cnt_q + 1'b1;
      // stall holds while the buffer is occupied, drops one edge after it drains
      stall_d = buf_valid_q && (stall_q || cnt_at_limit);
   end

   // controller state
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
         cnt_q       <= '0;
         stall_q     <= 1'b0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         cnt_q       <= cnt_d;
         stall_q     <= stall_d;
      end
   end

   assign clr_addr = (src == SRC_BUF) ? buf_addr_q : bus.mdu_addr;

   gpr_scoreboard u_sb (
      .clk           (clk),
      .rst           (rst),
      .issue_valid_i (bus.issue_valid),
      .issue_addr_i  (bus.issue_addr),
      .clr_valid_i   ((src == SRC_BUF) || (src == SRC_MDU)),
      .clr_addr_i    (clr_addr),
      .acc_valid_i   (mdu_acc),
      .acc_addr_i    (bus.mdu_addr),
      .buf_valid_i   (buf_valid_q),
      .buf_addr_i    (buf_addr_q),
      .rd_addr_0_i   (bus.rd_addr_0),
      .rd_addr_1_i   (bus.rd_addr_1),
      .hazard_0_o    (bus.hazard_0),
      .hazard_1_o    (bus.hazard_1),
      .sb_err_o      (bus.sb_err)
   );
endmodule

// File: doc/gpr_wb_ctrl.md
# gpr_wb_ctrl

Write-back controller for the general-purpose register file. It shares the file's single write port between the in-order execute write-back path and a long-latency unit (load/multiply-divide). Pending long-latency destinations are tracked in a scoreboard that drives read-hazard flags to decode. It sits between the pipeline write-back stage and the GPR file, and drives the file's active-low write enable, write address and write data.

## Interface
- STARVE_LIMIT, 4: consecutive blocked cycles of the holding buffer before a pipeline stall is forced (2..15).
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  execute write-back request; always accepted.
- ex_addr  in  GPR_ADDR_WIDTH  execute destination.
- ex_data  in  WORD_WIDTH  execute result.
- mdu_valid  in  1  long-latency result valid.
- mdu_ready  out  1  long-latency result accepted this cycle when high with mdu_valid.
- mdu_addr  in  GPR_ADDR_WIDTH  long-latency destination.
- mdu_data  in  WORD_WIDTH  long-latency result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_addr  in  GPR_ADDR_WIDTH  its destination; sets the scoreboard bit.
- rd_addr_0, rd_addr_1  in  GPR_ADDR_WIDTH  decode source addresses.
- hazard_0, hazard_1  out  1  the corresponding source is pending.
- pipe_stall  out  1  registered; the pipeline must hold ex_valid=0 while high.
- gpr_we_  out  1  GPR write enable, active-low (WRITE=0).
- gpr_wr_addr  out  GPR_ADDR_WIDTH  GPR write address.
- gpr_wr_data  out  WORD_WIDTH  GPR write data.
- sb_err  out  1  sticky error flag: issue to an already-pending register, or an mdu write to a non-pending register.

## Operation
- One-entry holding buffer (buf_valid, buf_addr, buf_data) for long-latency results.
- mdu_ready = !buf_valid; it is forced 0 while rst is high.
- Write-port selection, combinational, in priority order:
  1. ex_valid → write ex.
  2. else buf_valid → write the buffer; the buffer empties at the clock edge.
  3. else mdu_valid → write mdu directly (bypass; the buffer is not loaded).
- When ex_valid && mdu_valid && mdu_ready, the mdu result loads into the buffer.
- Writes to address 0 are suppressed: gpr_we_=1, but the source is still consumed and its scoreboard bit is cleared.
- Scoreboard: pending[31:1]; pending[0] is hard 0.
  - issue_valid sets pending[issue_addr].
  - Committing an mdu result (from the buffer or the bypass) clears pending[addr].
  - Same-cycle set and clear of the same address: the set wins.
- hazard_n = pending[rd_addr_n] | (buf_valid && buf_addr==rd_addr_n && rd_addr_n!=0). Combinational.
- sb_err sets when:
  - issue_valid targets a pending address, or
  - an accepted mdu result targets a non-pending nonzero address.
  - It is cleared only by rst.
- Starvation counter:
  - Increments each cycle that buf_valid && ex_valid; clears when buf_valid=0.
  - When it reaches STARVE_LIMIT, pipe_stall rises at the next edge.
  - pipe_stall falls at the edge after the buffer drains.
- ex_valid while pipe_stall=1 is a protocol violation. Ex still wins; this is flagged by a bench assertion only.

## Timing
- gpr_we_/addr/data are combinational from inputs and state. The GPR write lands at the next edge; same-cycle read forwarding is the file's job.
- Bypass latency is 0 cycles. A buffered result commits on the first cycle with ex_valid=0, at most STARVE_LIMIT+2 cycles after acceptance.
- pending updates are visible on hazard_n the cycle after issue_valid.
- Reset values while rst is high, and after it:
  - gpr_we_=1, gpr_wr_addr=0, gpr_wr_data=0.
  - mdu_ready=0, pipe_stall=0, sb_err=0.
  - hazard_0/1=0, pending=0, buf_valid=0, counter=0.
- Reset mid-operation discards the buffered result and all pending bits; no write occurs in the reset cycle.

## Structure
- Shared package/defines: GPR_ADDR_WIDTH (5), WORD_WIDTH (32), DATA_HIGH_GPR (32), WRITE/READ encodings, and a write-source enum {SRC_NONE, SRC_EX, SRC_BUF, SRC_MDU}.
- One natural sub-module: gpr_scoreboard (pending vector, set/clear, hazard lookup, sb_err). Arbitration, buffer and starvation counter live in the top.

## Test plan
- Reset: hold rst 3 cycles with ex_valid=1 and mdu_valid=1 → gpr_we_=1 and mdu_ready=0 throughout; all outputs at reset values after release.
- Bypass: issue x5, then 2 cycles later mdu_valid with addr 5, data 0xDEADBEEF, ex idle → gpr_we_=0, addr 5, data 0xDEADBEEF the same cycle; hazard_0 (rd_addr_0=5) high from issue+1 until the cycle after commit.
- Collision: ex writes x3=0x11 while mdu presents x7=0x22 → x3 written; next cycle with ex idle, x7=0x22 written from the buffer; mdu_ready low exactly one cycle.
- Starvation, STARVE_LIMIT=4: buffer held while ex_valid is continuous → pipe_stall rises after 4 blocked cycles; in the first ex-idle cycle the buffer commits; pipe_stall falls the next cycle.
- x0 and same-cycle set/clear: mdu result to x0 → no write, no sb_err. Commit of x9 in the same cycle as a reissue of x9 → pending[9] stays 1.
- Error: issue x4 twice without commit → sb_err=1 and stays 1 until rst.
